// File: rtl/port_collector_pkg.sv
// Shared types and constants for the three-port collector.
package port_collector_pkg;

  localparam int NUM_PORTS = 3;

  typedef logic [1:0] chan_t;

  localparam chan_t CH_P1 = 2'd0;
  localparam chan_t CH_P2 = 2'd1;
  localparam chan_t CH_P3 = 2'd2;

  function automatic chan_t next_chan(input chan_t c);
    return (c == CH_P3) ? CH_P1 : chan_t'(c + 2'd1);
  endfunction

endpackage

// File: rtl/port_collector_fifo.sv
// Synchronous FIFO; push while full is honoured only when a pop happens on the same edge.
module port_collector_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/port_collector.sv
// Absorbs three unthrottled port streams into FIFOs and merges them round-robin
// onto one valid/ready output tagged with the source channel.
module port_collector
  import port_collector_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] port1_data,
  input  logic [DATA_W-1:0] port2_data,
  input  logic [DATA_W-1:0] port3_data,
  input  logic              port1_valid,
  input  logic              port2_valid,
  input  logic              port3_valid,
  output logic [DATA_W-1:0] out_data,
  output chan_t             out_channel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        overflow,
  input  logic              clr_overflow
);

  logic [NUM_PORTS-1:0] in_valid;
  logic [NUM_PORTS-1:0] push;
  logic [NUM_PORTS-1:0] pop;
  logic [NUM_PORTS-1:0] full;
  logic [NUM_PORTS-1:0] empty;
  logic [NUM_PORTS-1:0] drop;
  logic [DATA_W-1:0]    in_data [NUM_PORTS];
  logic [DATA_W-1:0]    head    [NUM_PORTS];

  chan_t rr;
  chan_t grant_idx;
  chan_t cand;
  logic  grant_valid;
  logic  reg_free;

  assign in_valid   = {port3_valid, port2_valid, port1_valid};
  assign in_data[0] = port1_data;
  assign in_data[1] = port2_data;
  assign in_data[2] = port3_data;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_fifo
    port_collector_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[g]),
      .pop   (pop[g]),
      .wdata (in_data[g]),
      .rdata (head[g]),
      .full  (full[g]),
      .empty (empty[g])
    );
  end

  assign reg_free = !out_valid || out_ready;

  // First non-empty FIFO at or after rr, wrapping.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = rr;
    cand        = rr;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!grant_valid && !empty[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
      cand = next_chan(cand);
    end
  end

  always_comb begin
    pop  = '0;
    push = '0;
    drop = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      pop[i]  = reg_free && grant_valid && (grant_idx == chan_t'(i));
      push[i] = in_valid[i] && (!full[i] || pop[i]);
      drop[i] = in_valid[i] && full[i] && !pop[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr          <= CH_P1;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_channel <= CH_P1;
    end else if (reg_free) begin
      out_valid <= grant_valid;
      if (grant_valid) begin
        out_data    <= head[grant_idx];
        out_channel <= grant_idx;
        rr          <= next_chan(grant_idx);
      end
    end
  end

  // A drop coinciding with a clear keeps its bit set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= '0;
    end else begin
      overflow <= (clr_overflow ? 3'b000 : overflow) | drop;
    end
  end

endmodule
